down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Synchronous, loadable down counter with terminal-count detection; the count-down counterpart to the team's 4-bit ripple up counter.
- Counts from a programmed reload value to 0, either once (one-shot) or repeatedly (auto-reload).
- Reports terminal count and provides a combinational borrow output, so instances can be cascaded into wider counters or used as a timer tick source.

Parameters:
- WIDTH, 4, bit width of the counter and the reload value.
- RELOAD_DEFAULT, 15, value of the reload register and q after reset. Must fit in WIDTH bits.

Ports:
- clk  input  1  single system clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- load  input  1  captures load_value into the reload register and into q.
- load_value  input  WIDTH  value captured when load=1.
- start  input  1  begins or resumes counting.
- stop  input  1  halts counting; q holds its value.
- cnt_en  input  1  count enable, qualified per cycle; this is the cascade input from a lower stage's borrow_out.
- auto_reload  input  1  1 selects reload at 0; 0 selects one-shot. Sampled each cycle.
- q  output  WIDTH  current count (registered).
- tc  output  1  registered one-cycle terminal-count pulse.
- busy  output  1  registered; 1 while in state RUN.
- borrow_out  output  1  combinational: (state==RUN) & cnt_en & (q==0).

Behaviour:
- Reset: when reset=0 at a rising edge, the block sets:
  - q=RELOAD_DEFAULT
  - reload register=RELOAD_DEFAULT
  - state=IDLE
  - tc=0, busy=0
- Reset has the highest priority and aborts any operation, including a count in progress.
- FSM states are IDLE, RUN and DONE. busy=1 only in RUN.
- Per-edge priority is reset > load > stop > start > count.
- load=1, in any state:
  - reload register and q take load_value.
  - state goes to IDLE; tc=0.
  - A start in the same cycle is ignored.
- stop=1:
  - In RUN: state goes to IDLE and q holds.
  - In IDLE or DONE: no effect.
  - stop wins over a simultaneous start.
- start=1:
  - In IDLE: go to RUN; q is unchanged (resume).
  - In DONE: go to RUN and q takes the reload value.
  - In RUN: ignored.
  - The first decrement happens at the edge after the one that entered RUN.
- RUN with cnt_en=1:
  - If q!=0: q becomes q-1 and tc=0.
  - If q==0 and auto_reload=1: tc=1 for one cycle, q takes the reload value, state stays RUN.
  - If q==0 and auto_reload=0: tc=1 for one cycle, q stays 0, state goes to DONE.
- RUN with cnt_en=0: q holds and tc=0.
- Period: a reload value N gives one tc every N+1 enabled cycles.
  - N=0 with auto_reload gives tc on every enabled cycle.
- Wrap-around: q never decrements below 0. There is no wrap to all-ones.
- tc is 0 in every cycle other than the ones listed above.
- Cascade: the high stage's cnt_en is tied to the low stage's borrow_out, with a common clk, reset and start. The pair then counts as one 2*WIDTH down counter.
- Changing auto_reload mid-count takes effect at the next q==0 evaluation.

Test Plan:
- Reset check: hold reset=0 for 2 cycles, then release -> q=15, busy=0, tc=0, state IDLE.
- One-shot: load 3, start, cnt_en=1 -> q reads 3,2,1,0 on successive edges after entering RUN; tc=1 exactly one cycle; busy falls; q stays 0.
- Auto-reload: load 2, auto_reload=1, start, cnt_en=1 for 9 cycles -> q cycles 2,1,0,2,1,0,...; tc pulses every 3 cycles.
- Stop and resume: run from 10; assert stop when q=6 -> q holds at 6 and busy=0; start again -> continues 5,4,...
- Enable gating and simultaneous events:
  - Toggle cnt_en 1,0,1 -> q decrements only on enabled cycles.
  - Assert stop and start together -> IDLE.
  - Assert load with start -> q=load_value, IDLE.
- Cascade and reset mid-count:
  - Two 4-bit instances loaded 0x12 -> tc on the high stage after 0x13 enabled cycles.
  - reset=0 mid-run -> q=15, IDLE on the next edge.

Source files
------------

// File: rtl/down_counter_timer_if.sv
// ---------------------------------------------------------------------------
// down_counter_timer_if
//   Control and status bundle for one down_counter_timer stage.
//
//   Signals (directions are seen from the counter, i.e. the slave modport):
//     load        in   capture load_value into the reload register and count
//     load_value  in   WIDTH-bit value captured on load
//     start       in   begin or resume counting
//     stop        in   halt counting, count holds
//     cnt_en      in   per-cycle count enable / cascade input (lower borrow_out)
//     auto_reload in   1: reload at zero, 0: one-shot
//     q           out  current count (registered)
//     tc          out  one-cycle terminal-count pulse (registered)
//     busy        out  1 while counting is active (registered)
//     borrow_out  out  combinational cascade output to the next higher stage
//
//   master: the controlling side (system or testbench).
//   slave : the counter itself.
// ---------------------------------------------------------------------------
interface down_counter_timer_if #(
  parameter int WIDTH = 4
) ();

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             cnt_en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             borrow_out;

  modport master (
    output load,
    output load_value,
    output start,
    output stop,
    output cnt_en,
    output auto_reload,
    input  q,
    input  tc,
    input  busy,
    input  borrow_out
  );

  modport slave (
    input  load,
    input  load_value,
    input  start,
    input  stop,
    input  cnt_en,
    input  auto_reload,
    output q,
    output tc,
    output busy,
    output borrow_out
  );

endinterface : down_counter_timer_if

// File: rtl/down_counter_timer.sv
// ---------------------------------------------------------------------------
// down_counter_timer
//   Synchronous loadable down counter with terminal-count detection.
//   Counts from a programmed reload value down to zero, either once
//   (one-shot) or repeatedly (auto-reload). A reload value N produces one
//   terminal-count pulse every N+1 enabled cycles.
//
//   Stages can be cascaded into a wider counter by tying the higher stage's
//   cnt_en to the lower stage's borrow_out, with clk, reset and start shared.
//
//   Ports:
//     clk    in  system clock, all registers update on its rising edge
//     reset  in  synchronous active-low reset
//     bus    slave modport of down_counter_timer_if:
//              load, load_value, start, stop, cnt_en, auto_reload (inputs)
//              q, tc, busy (registered outputs), borrow_out (combinational)
//
//   Parameters:
//     WIDTH          counter / reload width (must match the interface WIDTH)
//     RELOAD_DEFAULT value of the reload register and q after reset
// ---------------------------------------------------------------------------
module down_counter_timer #(
  parameter int WIDTH          = 4,
  parameter int RELOAD_DEFAULT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  down_counter_timer_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RELOAD_INIT = WIDTH'(RELOAD_DEFAULT);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic             tc_r;
  logic             busy_r;
  logic             at_zero;

  // Decrement that floors at zero: the counter never wraps to all-ones.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    if (v == '0) begin
      return '0;
    end
    return v - WIDTH'(1);
  endfunction

  assign at_zero = (count == '0);

  // Single FSM block. Priority on each edge is
  // reset > load > stop > start > count; the if/else chain encodes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= RELOAD_INIT;
      reload <= RELOAD_INIT;
      tc_r   <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      // tc is a single-cycle pulse; only the terminal-count branch raises it.
      tc_r <= 1'b0;

      if (bus.load) begin
        // Load aborts everything, including a same-cycle start.
        reload <= bus.load_value;
        count  <= bus.load_value;
        state  <= IDLE;
        busy_r <= 1'b0;
      end else if (bus.stop) begin
        // Only meaningful while running; in IDLE/DONE stop simply
        // suppresses a simultaneous start.
        if (state == RUN) begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      end else if (bus.start && (state != RUN)) begin
        // From IDLE this resumes with the held count; from DONE the
        // count is rearmed from the reload register. No decrement on
        // the entry edge.
        if (state == DONE) begin
          count <= reload;
        end
        state  <= RUN;
        busy_r <= 1'b1;
      end else if ((state == RUN) && bus.cnt_en) begin
        // A start while already running falls through to here and is
        // effectively ignored.
        if (!at_zero) begin
          count <= sat_dec(count);
        end else begin
          tc_r <= 1'b1;
          if (bus.auto_reload) begin
            count <= reload;
          end else begin
            // One-shot: park at zero until rearmed.
            state  <= DONE;
            busy_r <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.q          = count;
  assign bus.tc         = tc_r;
  assign bus.busy       = busy_r;
  // Combinational so the next stage decrements on the same edge at which
  // this stage reaches its terminal count.
  assign bus.borrow_out = (state == RUN) && bus.cnt_en && at_zero;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  localparam int W  = 4;
  localparam int RD = 15;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  down_counter_timer_if #(.WIDTH(W)) lo_if ();
  down_counter_timer_if #(.WIDTH(W)) hi_if ();

  down_counter_timer #(.WIDTH(W), .RELOAD_DEFAULT(RD)) u_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (lo_if.slave)
  );

  down_counter_timer #(.WIDTH(W), .RELOAD_DEFAULT(RD)) u_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (hi_if.slave)
  );

  // High stage counts on the low stage's borrow.
  assign hi_if.cnt_en = lo_if.borrow_out;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference for the low stage ----------------
  // The model describes the timer as "is it counting", "has it finished" and
  // an integer count, following the documented rules directly.
  int m_count, m_reload;
  bit m_counting, m_finished, m_tc, m_valid;

  task automatic model_step();
    if (!reset) begin
      m_count = RD; m_reload = RD;
      m_counting = 0; m_finished = 0; m_tc = 0; m_valid = 1;
      return;
    end
    m_tc = 0;
    if (lo_if.load) begin
      m_reload = int'(lo_if.load_value);
      m_count  = m_reload;
      m_counting = 0; m_finished = 0;
    end else if (lo_if.stop) begin
      if (m_counting) m_counting = 0;
    end else if (lo_if.start && !m_counting) begin
      if (m_finished) m_count = m_reload;
      m_finished = 0; m_counting = 1;
    end else if (m_counting && lo_if.cnt_en) begin
      if (m_count > 0) begin
        m_count = m_count - 1;
      end else begin
        m_tc = 1;
        if (lo_if.auto_reload) m_count = m_reload;
        else begin m_counting = 0; m_finished = 1; end
      end
    end
  endtask

  // One clock: check the combinational borrow on current inputs, advance the
  // model, let the edge happen, then compare registered outputs.
  task automatic tick();
    #2;
    if (m_valid && reset)
      chk("borrow", 32'(lo_if.borrow_out),
          32'(m_counting && lo_if.cnt_en && (m_count == 0)));
    model_step();
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("q",    32'(lo_if.q),    32'(m_count));
      chk("tc",   32'(lo_if.tc),   32'(m_tc));
      chk("busy", 32'(lo_if.busy), 32'(m_counting));
    end
  endtask

  task automatic drive(input bit ld, input int lv, input bit st, input bit sp,
                       input bit en, input bit ar);
    lo_if.load = ld; lo_if.load_value = W'(lv); lo_if.start = st;
    lo_if.stop = sp; lo_if.cnt_en = en; lo_if.auto_reload = ar;
  endtask

  int tc_seen;
  int combined;

  initial begin
    m_valid = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    hi_if.load = 0; hi_if.load_value = '0; hi_if.start = 0;
    hi_if.stop = 0; hi_if.auto_reload = 0;

    // Reset held two cycles.
    tick(); tick();
    reset = 1'b1;
    chk("rst_q", 32'(lo_if.q), 32'd15);
    chk("rst_busy", 32'(lo_if.busy), 32'd0);
    chk("rst_tc", 32'(lo_if.tc), 32'd0);
    tick();
    chk("idle_q", 32'(lo_if.q), 32'd15);

    // One-shot from 3.
    drive(1, 3, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 0, 1, 0); tick();
    chk("os_enter", 32'(lo_if.q), 32'd3);
    drive(0, 0, 0, 0, 1, 0);
    tick(); chk("os_q2", 32'(lo_if.q), 32'd2);
    tick(); chk("os_q1", 32'(lo_if.q), 32'd1);
    tick(); chk("os_q0", 32'(lo_if.q), 32'd0);
    tick(); chk("os_tc", 32'(lo_if.tc), 32'd1);
    chk("os_busy", 32'(lo_if.busy), 32'd0);
    tick(); chk("os_tc_off", 32'(lo_if.tc), 32'd0);
    chk("os_hold", 32'(lo_if.q), 32'd0);

    // Restart from DONE rearms from reload.
    drive(0, 0, 1, 0, 1, 0); tick();
    chk("rearm", 32'(lo_if.q), 32'd3);

    // Auto-reload from 2: nine enabled cycles give three tc pulses.
    drive(1, 2, 0, 0, 1, 1); tick();
    drive(0, 0, 1, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 1, 1);
    tc_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (lo_if.tc) tc_seen++;
    end
    chk("ar_tc_count", 32'(tc_seen), 32'd3);

    // Reload 0 with auto-reload: tc on every enabled cycle.
    drive(1, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 1, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 1, 1);
    tick(); chk("n0_tc_a", 32'(lo_if.tc), 32'd1);
    tick(); chk("n0_tc_b", 32'(lo_if.tc), 32'd1);

    // Stop at 6 then resume.
    drive(1, 10, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("sr_at6", 32'(lo_if.q), 32'd6);
    drive(0, 0, 0, 1, 1, 0); tick();
    chk("sr_hold", 32'(lo_if.q), 32'd6);
    chk("sr_busy", 32'(lo_if.busy), 32'd0);
    drive(0, 0, 1, 0, 1, 0); tick();
    chk("sr_resume", 32'(lo_if.q), 32'd6);
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("sr_q5", 32'(lo_if.q), 32'd5);

    // Enable gating 1,0,1.
    drive(0, 0, 0, 0, 1, 0); tick(); chk("en1", 32'(lo_if.q), 32'd4);
    drive(0, 0, 0, 0, 0, 0); tick(); chk("en0", 32'(lo_if.q), 32'd4);
    drive(0, 0, 0, 0, 1, 0); tick(); chk("en1b", 32'(lo_if.q), 32'd3);

    // stop with start while running -> IDLE.
    drive(0, 0, 1, 1, 1, 0); tick();
    chk("ss_busy", 32'(lo_if.busy), 32'd0);
    chk("ss_q", 32'(lo_if.q), 32'd3);

    // load with start -> load value, IDLE.
    drive(1, 9, 1, 0, 1, 0); tick();
    chk("ls_q", 32'(lo_if.q), 32'd9);
    chk("ls_busy", 32'(lo_if.busy), 32'd0);

    // Reset mid-run.
    drive(0, 0, 1, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick(); tick();
    reset = 1'b0; tick(); reset = 1'b1;
    chk("mid_rst_q", 32'(lo_if.q), 32'd15);
    chk("mid_rst_busy", 32'(lo_if.busy), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      drive(($urandom_range(0, 19) == 0), $urandom_range(0, 7), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      tick();
    end
    reset = 1'b1;

    // Cascade: load low 0xF, high 1; run low alone down to 2 so the pair
    // holds 0x12 with a low-stage reload of 0xF, as a true 8-bit counter.
    drive(1, 15, 0, 0, 0, 1);
    hi_if.load = 1; hi_if.load_value = W'(1); hi_if.auto_reload = 0;
    tick();
    hi_if.load = 0;
    drive(0, 0, 1, 0, 0, 1); hi_if.start = 1; tick();
    drive(0, 0, 0, 0, 1, 1); hi_if.start = 0;
    for (int i = 0; i < 13; i++) tick();
    combined = int'(hi_if.q) * 16 + int'(lo_if.q);
    chk("cas_start", 32'(combined), 32'h12);
    for (int k = 1; k <= 19; k++) begin
      tick();
      combined = int'(hi_if.q) * 16 + int'(lo_if.q);
      if (k <= 18) chk("cas_val", 32'(combined), 32'(8'h12 - k));
      chk("cas_hi_tc", 32'(hi_if.tc), 32'(k == 19));
    end
    chk("cas_hi_busy", 32'(hi_if.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_down_counter_timer
